pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the en/flush inputs of the if_id, id_ex, ex_mem and mem_wb latches, plus the PC enable.
- Arbitrates instruction-fetch waits, data-memory waits, load-use hazards, MEM-stage redirects and halt.
- Holds a small FSM for data waits and halt, and a saturating stall-cycle counter.

Parameters:
- REGW, 5, register index width.
- CNT_W, 32, stall counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ihit  in  1  fetch data valid this cycle.
- dhit  in  1  data access complete this cycle (pulse).
- mem_dREN  in  1  instruction in MEM reads memory.
- mem_dWEN  in  1  instruction in MEM writes memory.
- ex_dREN  in  1  instruction in EX is a load.
- ex_regWr  in  1  instruction in EX writes a register.
- ex_rd  in  REGW  destination register of the EX instruction.
- id_rs1  in  REGW  source 1 of the ID instruction.
- id_rs2  in  REGW  source 2 of the ID instruction.
- id_uses_rs2  in  1  ID instruction reads rs2.
- br_taken  in  1  redirect resolved in MEM (branch taken or jump).
- wb_halt  in  1  halt instruction in WB.
- pc_en  out  1  PC update enable.
- ifid_en, ifid_flush  out  1 each  if_id latch controls.
- idex_en, idex_flush  out  1 each  id_ex latch controls.
- exmem_en, exmem_flush  out  1 each  ex_mem latch controls.
- memwb_en, memwb_flush  out  1 each  mem_wb latch controls.
- halt  out  1  registered, sticky halt.
- stall_cnt  out  CNT_W  count of cycles with pc_en=0 while not halted.

Behaviour:
- States: RUN, DWAIT, HALTED. On reset: state=RUN, halt=0, stall_cnt=0.
- While RST=1, all comb outputs (en, flush, pc_en) are forced to 0.
- The latch contract is fixed: flush has priority over en; en=0 with flush=0 holds the latch.
- mem_req = mem_dREN | mem_dWEN.
- dstall = (state==RUN & mem_req & !dhit) | (state==DWAIT & !dhit).
- luse = ex_dREN & ex_regWr & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- Default (RUN, no event): all en=1, all flush=0, pc_en=1.
- Priority, highest first: HALTED > dstall > br_taken > luse > !ihit.
- HALTED: all en=0, all flush=0, pc_en=0. Leaves only on RST.
- dstall: all en=0, all flush=0, pc_en=0 (full freeze).
  - RUN->DWAIT on the first dstall cycle.
  - DWAIT->RUN on the dhit cycle; that cycle applies the lower-priority rules as in RUN.
- br_taken: ifid_flush=1, idex_flush=1, exmem_flush=1, memwb_en=1, pc_en=1 (PC loads the target). The lower-priority rules are ignored.
- luse: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. This inserts exactly one bubble; on the next cycle the load is in MEM and luse deasserts.
- !ihit: pc_en=0, ifid_flush=1, remaining stages advance (en=1).
- Simultaneous luse and !ihit: the luse outputs apply. ifid is held, not flushed, so the ID instruction is preserved.
- Halt: wb_halt=1 in any state except HALTED -> HALTED next edge. halt=1 from the next cycle.
- stall_cnt: increments when pc_en=0 and state!=HALTED. Saturates at all-ones with no wrap.
- Reset mid-DWAIT or mid-HALTED returns to RUN with the counter cleared.

Decomposition:
- Add the enum ctrl_state_t {RUN, DWAIT, HALTED} (2 bits) to cpu_types_pkg. regbits_t (REGW wide) is reused from that package.
- Sub-module hazard_detect (combinational): computes luse from the ex_*/id_* inputs. Everything else stays in pipeline_ctrl.

Test Plan:
- RST=1 for 2 cycles, then release with ihit=1 and all other inputs 0 -> all en=1, flushes=0, pc_en=1, halt=0, stall_cnt=0.
- mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles of full freeze with state DWAIT, stall_cnt=3; dhit cycle gives all en=1 and the next state is RUN.
- ex_dREN=1, ex_regWr=1, ex_rd=5, id_rs1=5 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle. Repeat with ex_rd=0 and expect no stall.
- br_taken=1 together with luse=1 and ihit=0 -> ifid/idex/exmem flush=1, pc_en=1, memwb_en=1, and no stall counted.
- wb_halt=1 during a dstall -> halt=1 on the next cycle, all outputs 0 thereafter. RST=1 clears halt asynchronously.
- Force stall_cnt near saturation (CNT_W=4, 16 stall cycles) -> the counter holds at 15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index width and the pipeline controller state encoding.
package cpu_types_pkg;

  localparam int REGIDX_W = 5;

  typedef logic [REGIDX_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and latch-control outputs of the pipeline stall/flush controller.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  import cpu_types_pkg::*;

  logic             ihit;
  logic             dhit;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             ex_dREN;
  logic             ex_regWr;
  regbits_t         ex_rd;
  regbits_t         id_rs1;
  regbits_t         id_rs2;
  logic             id_uses_rs2;
  logic             br_taken;
  logic             wb_halt;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             memwb_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_regWr, ex_rd,
           id_rs1, id_rs2, id_uses_rs2, br_taken, wb_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, memwb_flush, halt, stall_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_regWr, ex_rd,
           id_rs1, id_rs2, id_uses_rs2, br_taken, wb_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, memwb_flush, halt, stall_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: the EX load writes a register the ID instruction is about to read.
module hazard_detect #(
  parameter int REGW = 5
) (
  input  logic            i_ex_dREN,
  input  logic            i_ex_regWr,
  input  logic [REGW-1:0] i_ex_rd,
  input  logic [REGW-1:0] i_id_rs1,
  input  logic [REGW-1:0] i_id_rs2,
  input  logic            i_id_uses_rs2,
  output logic            o_luse
);

  logic w_rd_nz;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign w_rd_nz   = |i_ex_rd;
  assign w_rs1_hit = (i_ex_rd == i_id_rs1);
  assign w_rs2_hit = i_id_uses_rs2 & (i_ex_rd == i_id_rs2);
  assign o_luse    = i_ex_dREN & i_ex_regWr & w_rd_nz & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: drives latch en/flush and PC enable,
// tracks data-memory waits and halt, and counts stalled cycles.
//   state  | meaning
//   RUN    | normal issue, lower-priority hazards arbitrated
//   DWAIT  | data access outstanding, pipeline frozen until dhit
//   HALTED | halt retired, everything frozen until reset
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REGW  = REGIDX_W,
  parameter int CNT_W = 32
) (
  input  logic           CLK,
  input  logic           RST,
  pipeline_ctrl_if.slave bus
);

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_mem_req;
  logic w_dstall;
  logic w_luse;
  logic w_pc_en;
  logic w_ifid_en, w_ifid_flush;
  logic w_idex_en, w_idex_flush;
  logic w_exmem_en, w_exmem_flush;
  logic w_memwb_en, w_memwb_flush;

  hazard_detect #(.REGW(REGW)) u_hazard_detect (
    .i_ex_dREN     (bus.ex_dREN),
    .i_ex_regWr    (bus.ex_regWr),
    .i_ex_rd       (bus.ex_rd),
    .i_id_rs1      (bus.id_rs1),
    .i_id_rs2      (bus.id_rs2),
    .i_id_uses_rs2 (bus.id_uses_rs2),
    .o_luse        (w_luse)
  );

  assign w_mem_req = bus.mem_dREN | bus.mem_dWEN;
  assign w_dstall  = ((r_state == RUN) & w_mem_req & ~bus.dhit) |
                     ((r_state == DWAIT) & ~bus.dhit);

  always_comb begin
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_en     = 1'b1;
    w_idex_flush  = 1'b0;
    w_exmem_en    = 1'b1;
    w_exmem_flush = 1'b0;
    w_memwb_en    = 1'b1;
    w_memwb_flush = 1'b0;
    if (RST || (r_state == HALTED) || w_dstall) begin
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_en = 1'b0;
      w_memwb_en = 1'b0;
    end else if (bus.br_taken) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
    end else if (w_luse) begin
      // hold ifid (never flush) so the dependent instruction survives a concurrent fetch miss
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
    end else if (!bus.ihit) begin
      w_pc_en      = 1'b0;
      w_ifid_flush = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN, DWAIT: begin
        if (bus.wb_halt)   w_state_nxt = HALTED;
        else if (w_dstall) w_state_nxt = DWAIT;
        else               w_state_nxt = RUN;
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_en && (r_state != HALTED) && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.pc_en       = w_pc_en;
  assign bus.ifid_en     = w_ifid_en;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_en     = w_idex_en;
  assign bus.idex_flush  = w_idex_flush;
  assign bus.exmem_en    = w_exmem_en;
  assign bus.exmem_flush = w_exmem_flush;
  assign bus.memwb_en    = w_memwb_en;
  assign bus.memwb_flush = w_memwb_flush;
  assign bus.halt        = (r_state == HALTED);
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a spec model pushes expected outputs per cycle,
// which are popped and compared against the DUT on the falling edge.
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  localparam int CW = 4;

  logic CLK = 1'b0;
  logic RST;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [13:0] exp;
    logic [13:0] mask;
    logic [1:0]  st;
    string       tag;
  } sb_t;

  sb_t         sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          m_st;
  logic [CW-1:0] m_cnt;

  function automatic logic [13:0] observe();
    return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
            bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.memwb_flush,
            bus.halt, bus.stall_cnt};
  endfunction

  task automatic drive(input logic ih, input logic dh, input logic mr, input logic mw,
                       input logic exr, input logic exw, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                       input logic br, input logic wh);
    bus.ihit = ih;  bus.dhit = dh;  bus.mem_dREN = mr;  bus.mem_dWEN = mw;
    bus.ex_dREN = exr;  bus.ex_regWr = exw;  bus.ex_rd = rd;
    bus.id_rs1 = r1;  bus.id_rs2 = r2;  bus.id_uses_rs2 = u2;
    bus.br_taken = br;  bus.wb_halt = wh;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict, sample at negedge, then advance the model after the edge.
  task automatic step(input string tag);
    logic       luse, dstall, pc;
    logic [9:0] ctl, msk;
    int         nst;
    sb_t        e, g;
    logic [13:0] obs;
    if (RST) begin
      m_st  = 0;
      m_cnt = '0;
    end
    luse = bus.ex_dREN && bus.ex_regWr && (bus.ex_rd != 5'd0) &&
           ((bus.ex_rd == bus.id_rs1) || (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));
    dstall = ((m_st == 0) && (bus.mem_dREN || bus.mem_dWEN) && !bus.dhit) ||
             ((m_st == 1) && !bus.dhit);
    msk = 10'b11_1111_1111;
    if (RST || (m_st == 2) || dstall) begin
      ctl = 10'b00_0000_0000;
    end else if (bus.br_taken) begin
      ctl = 10'b10_1010_1100;
      msk = 10'b10_1010_1111;
    end else if (luse) begin
      ctl = 10'b00_0011_0100;
      msk = 10'b11_1011_1111;
    end else if (!bus.ihit) begin
      ctl = 10'b00_1101_0100;
      msk = 10'b10_1111_1111;
    end else begin
      ctl = 10'b11_0101_0100;
    end
    ctl[0] = (m_st == 2);
    pc = ctl[9];
    nst = m_st;
    if (m_st != 2) begin
      if (bus.wb_halt) nst = 2;
      else if (dstall) nst = 1;
      else             nst = 0;
    end
    e.exp = {ctl, m_cnt};
    e.mask = {msk, 4'hF};
    e.st = 2'(m_st);
    e.tag = tag;
    sb_q.push_back(e);

    @(negedge CLK);
    g = sb_q.pop_front();
    obs = observe();
    n_assert++;
    assert ((obs & g.mask) === (g.exp & g.mask)) else begin
      n_fail++;
      $error("FAIL %s: outputs observed %b expected %b mask %b", g.tag, obs, g.exp, g.mask);
    end
    n_assert++;
    assert (dut.r_state === ctrl_state_t'(g.st)) else begin
      n_fail++;
      $error("FAIL %s_state: observed %0d expected %0d", g.tag, dut.r_state, g.st);
    end

    @(posedge CLK);
    #1;
    if (!RST) begin
      if (!pc && (m_st != 2) && (m_cnt != '1)) m_cnt = m_cnt + 1'b1;
      m_st = nst;
    end
  endtask

  initial begin
    m_st  = 0;
    m_cnt = '0;
    RST   = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("rst0");
    step("rst1");

    RST = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("idle0");
    step("idle1");

    drive(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("dfreeze0");
    step("dfreeze1");
    step("dfreeze2");
    chk("dstall_cnt", 32'(bus.stall_cnt), 32'd3);
    drive(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("dhit");
    drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("after_dhit");

    drive(1, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
    step("luse_rs1");
    drive(1, 1, 1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
    step("load_in_mem");
    drive(1, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("luse_x0");
    drive(1, 0, 0, 0, 1, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0);
    step("luse_rs2");
    drive(1, 0, 0, 0, 1, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0);
    step("no_rs2_use");
    drive(0, 0, 0, 0, 1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0);
    step("luse_and_imiss");
    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("imiss");
    drive(0, 0, 0, 0, 1, 1, 5'd9, 5'd9, 5'd0, 0, 1, 0);
    step("br_luse_imiss");
    chk("br_no_stall_cnt", 32'(bus.stall_cnt), 32'd7);

    drive(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("halt_dstall0");
    drive(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    step("halt_dstall1");
    drive(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    step("halted0");
    step("halted1");
    chk("halted_cnt", 32'(bus.stall_cnt), 32'd9);

    RST = 1'b1;
    #1;
    chk("async_halt_clr", 32'(bus.halt), 32'd0);
    chk("async_cnt_clr", 32'(bus.stall_cnt), 32'd0);
    step("halt_rst");
    RST = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("post_halt");

    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 18; i++) step($sformatf("sat%0d", i));
    chk("sat_cnt", 32'(bus.stall_cnt), 32'd15);

    drive(1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    RST = 1'b1;
    step("sat_rst");
    RST = 1'b0;
    step("dwait_w0");
    step("dwait_w1");
    RST = 1'b1;
    #1;
    chk("dwait_rst_state", 32'(dut.r_state), 32'(RUN));
    step("dwait_rst");
    RST = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("post_dwait_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
